imm_extend_unit: RTL and testbench

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

---
 rtl/mips_pkg.sv | 11 +
 rtl/imm_ext_core.sv | 35 +++
 rtl/imm_extend_unit.sv | 62 ++++++
 tb/tb_imm_extend_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the immediate-extension datapath.
package mips_pkg;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  typedef logic [1:0] imm_mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign/zero/upper/branch forms.
module imm_ext_core
  import mips_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  imm_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] branch_ext;

  assign sign_ext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zero_ext   = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper_ext  = {imm, {(OUT_W-IN_W){1'b0}}};
  // Word-offset branch form: sign result scaled by 4, top two bits dropped.
  assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};

  always_comb begin
    ext = sign_ext;
    case (mode)
      MODE_SIGN:   ext = sign_ext;
      MODE_ZERO:   ext = zero_ext;
      MODE_UPPER:  ext = upper_ext;
      MODE_BRANCH: ext = branch_ext;
      default:     ext = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate extender with a two-entry (output + skid) valid/ready buffer.
module imm_extend_unit
  import mips_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  logic [OUT_W-1:0] ext;
  logic             or_valid;
  logic [OUT_W-1:0] or_data;
  logic             sk_valid;
  logic [OUT_W-1:0] sk_data;
  logic             accept;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext)
  );

  // in_ready comes straight from the skid flop, so out_ready never reaches it.
  assign in_ready  = !sk_valid;
  assign accept    = in_valid && in_ready;
  assign out_valid = or_valid;
  assign out_data  = or_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
    end else if (!or_valid || out_ready) begin
      // Output register is free this edge; the skid entry is older than any new beat.
      if (sk_valid) begin
        or_valid <= 1'b1;
        or_data  <= sk_data;
        sk_valid <= 1'b0;
      end else if (accept) begin
        or_valid <= 1'b1;
        or_data  <= ext;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (accept) begin
      sk_valid <= 1'b1;
      sk_data  <= ext;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed and randomized checks of imm_extend_unit against an arithmetic reference.
module tb_imm_extend_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int failures = 0;

  imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_ext(input int unsigned imm, input int unsigned mode);
    longint s;
    s = longint'(imm);
    if (s >= 32768) s = s - 65536;
    case (mode)
      0:       return 32'(s);
      1:       return 32'(imm);
      2:       return 32'(longint'(imm) * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic single(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp,
                        input string tag);
    in_imm = imm; in_mode = mode; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp);
    step();
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_a, exp_b, exp_c;
  logic [31:0] held;
  logic        was_stalled, do_acc, do_drn;
  int          sent, got, cyc;
  int unsigned r_imm, r_mode;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    single(16'h8000, 2'b00, 32'hFFFF8000, "sign_neg");
    single(16'h7FFF, 2'b00, 32'h00007FFF, "sign_pos");
    single(16'h8000, 2'b01, 32'h00008000, "zero");
    single(16'h1234, 2'b10, 32'h12340000, "upper");
    single(16'hFFFF, 2'b11, 32'hFFFFFFFC, "branch_neg");
    single(16'h0001, 2'b11, 32'h00000004, "branch_pos");

    // Backpressure: A and B buffered, C stalls, then all drain in order.
    exp_a = ref_ext(16'hA001, 0); exp_b = ref_ext(16'h0B02, 2); exp_c = ref_ext(16'hC003, 3);
    out_ready = 1'b0;
    in_imm = 16'hA001; in_mode = 2'b00; in_valid = 1'b1;
    step();
    in_imm = 16'h0B02; in_mode = 2'b10;
    check("bp_in_ready_b", 32'(in_ready), 32'd1);
    step();
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    in_imm = 16'hC003; in_mode = 2'b11;
    step(); step();
    check("bp_stall_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_a", out_data, exp_a);
    out_ready = 1'b1;
    step();
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b", out_data, exp_b);
    step();
    in_valid = 1'b0;
    check("bp_c_valid", 32'(out_valid), 32'd1);
    check("bp_c", out_data, exp_c);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Streaming at full rate with alternating modes.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r_imm = $urandom_range(0, 65535);
      r_mode = i % 4;
      in_imm = 16'(r_imm); in_mode = 2'(r_mode); in_valid = 1'b1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", out_data, ref_ext(r_imm, r_mode));
    end
    in_valid = 1'b0;
    step();
    check("stream_done", 32'(out_valid), 32'd0);

    // Reset while both entries are full and a beat is offered.
    out_ready = 1'b0;
    in_imm = 16'h1111; in_mode = 2'b01; in_valid = 1'b1;
    step();
    in_imm = 16'h2222;
    step();
    check("rst_full_in_ready", 32'(in_ready), 32'd0);
    in_imm = 16'h3333;
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check("rst_full_out_valid", 32'(out_valid), 32'd0);
    check("rst_full_out_data", out_data, 32'h0);
    check("rst_full_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized traffic against a FIFO scoreboard.
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      check("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
      r_imm = $urandom_range(0, 65535);
      r_mode = $urandom_range(0, 3);
      in_imm = 16'(r_imm); in_mode = 2'(r_mode);
      in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      do_acc = in_valid && in_ready;
      do_drn = out_valid && out_ready;
      was_stalled = out_valid && !out_ready;
      held = out_data;
      if (do_drn) begin
        check("rnd_order", out_data, (q.size() > 0) ? q.pop_front() : ~out_data);
        got++;
      end
      if (do_acc) begin
        q.push_back(ref_ext(r_imm, r_mode));
        sent++;
      end
      step();
      if (was_stalled) begin
        check("rnd_hold_valid", 32'(out_valid), 32'd1);
        check("rnd_hold_data", out_data, held);
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_received", 32'(got), 32'd1000);
    check("rnd_queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
